// File: rtl/alu_bd_be_pkg.sv
// alu_bd_be_pkg -- shared constants for the ALU / byte-enable / delay-slot block.
//   aluop_e      : ALU operation codes
//   EXC_*        : exception codes driven on alu_error / be_error
//   HBW_*        : access-size codes
//   IO*_ / DM_*  : data-memory and device-register address map
package alu_bd_be_pkg;

   typedef enum logic [4:0] {
      OP_ADDU = 5'd0,  OP_SUBU = 5'd1,  OP_ADD  = 5'd2,  OP_SUB  = 5'd3,
      OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_NOR  = 5'd7,
      OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_SLL  = 5'd10, OP_SRL  = 5'd11,
      OP_SRA  = 5'd12, OP_LUI  = 5'd13, OP_ADDL = 5'd14, OP_ADDS = 5'd15
   } aluop_e;

   localparam logic [3:0] EXC_NONE = 4'd0;
   localparam logic [3:0] EXC_ADEL = 4'd4;
   localparam logic [3:0] EXC_ADES = 4'd5;
   localparam logic [3:0] EXC_OV   = 4'd12;

   localparam logic [1:0] HBW_WORD = 2'b00;
   localparam logic [1:0] HBW_HALF = 2'b01;
   localparam logic [1:0] HBW_BYTE = 2'b10;
   localparam logic [1:0] HBW_NONE = 2'b11;

   localparam logic [31:0] DM_TOP_DEFAULT = 32'h0000_2FFF;
   localparam logic [31:0] IO0_BASE = 32'h0000_7F00;
   localparam logic [31:0] IO0_LAST = 32'h0000_7F0B;
   localparam logic [31:0] IO1_BASE = 32'h0000_7F10;
   localparam logic [31:0] IO1_LAST = 32'h0000_7F1B;
   // Read-only device registers: stores here are rejected.
   localparam logic [31:0] IO0_RO   = 32'h0000_7F08;
   localparam logic [31:0] IO1_RO   = 32'h0000_7F18;

   // Signed overflow of a+b: operands agree in sign, sum does not.
   function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] s);
      return (a[31] == b[31]) && (s[31] != a[31]);
   endfunction

   // Signed overflow of a-b: operands differ in sign, difference differs from a.
   function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] d);
      return (a[31] != b[31]) && (d[31] != a[31]);
   endfunction

endpackage

// File: rtl/alu_bd_be_byte_enable_gen.sv
// byte_enable_gen -- byte enables and access exceptions for the M-stage access.
//   addr     in  32  effective address (ALU result)
//   hbw      in  2   access size: word / half / byte / none
//   is_store in  1   1 = store, 0 = load
//   be_out   out 4   byte enables, forced to 0 on any access error
//   be_error out 4   EXC_ADEL / EXC_ADES / EXC_NONE
// Optional feature macro: ADDR_RANGE_CHECK_EN adds address-map checking on top
// of the alignment check.
module byte_enable_gen
   import alu_bd_be_pkg::*;
#(
   parameter logic [31:0] DM_TOP = DM_TOP_DEFAULT
) (
   input  logic [31:0] addr,
   input  logic [1:0]  hbw,
   input  logic        is_store,
   output logic [3:0]  be_out,
   output logic [3:0]  be_error
);

   logic [3:0] be_raw;
   logic       misalign;
   logic       range_err;
   logic       err;

`ifdef ADDR_RANGE_CHECK_EN
   logic in_dm, in_io;
   always_comb begin
      in_dm     = (addr <= DM_TOP);
      in_io     = ((addr >= IO0_BASE) && (addr <= IO0_LAST)) ||
                  ((addr >= IO1_BASE) && (addr <= IO1_LAST));
      // Device registers are word-only; two of them are read-only.
      range_err = !(in_dm || in_io) ||
                  (in_io && (hbw != HBW_WORD)) ||
                  (is_store && ((addr == IO0_RO) || (addr == IO1_RO)));
   end
`else
   logic unused_addr;
   assign unused_addr = ^{addr[31:2], DM_TOP};
   assign range_err   = 1'b0;
`endif

   always_comb begin
      be_raw   = 4'b0000;
      misalign = 1'b0;
      case (hbw)
         HBW_WORD: begin be_raw = 4'b1111;                        misalign = (addr[1:0] != 2'b00); end
         HBW_HALF: begin be_raw = 4'b0011 << {addr[1], 1'b0};     misalign = addr[0];              end
         HBW_BYTE: begin be_raw = 4'b0001 << addr[1:0];                                            end
         default:  begin be_raw = 4'b0000;                                                         end
      endcase
      err      = (hbw != HBW_NONE) && (misalign || range_err);
      be_out   = err ? 4'b0000 : be_raw;
      be_error = err ? (is_store ? EXC_ADES : EXC_ADEL) : EXC_NONE;
   end

endmodule

// File: rtl/alu_bd_be.sv
// alu_bd_be -- combinational ALU, byte-enable generation and W-stage
// delay-slot tracking.
//   clk, reset (async, active low)
//   src1, src2, aluop -> result, alu_error   (zero latency)
//   instr[29], hbw    -> be_out, be_error    (addressed by result)
//   bd, pc_w          -> bdout (registered), pc_wout (EPC candidate)
// Optional feature macro: ADDR_RANGE_CHECK_EN (address-map checks in
// byte_enable_gen).
module alu_bd_be
   import alu_bd_be_pkg::*;
#(
   parameter logic [31:0] DM_TOP = DM_TOP_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic [4:0]  aluop,
   output logic [31:0] result,
   output logic [3:0]  alu_error,
   input  logic [31:0] instr,
   input  logic [1:0]  hbw,
   output logic [3:0]  be_out,
   output logic [3:0]  be_error,
   input  logic [31:0] pc_w,
   input  logic        bd,
   output logic        bdout,
   output logic [31:0] pc_wout
);

   logic [31:0] sum, diff;
   logic        unused_instr;

   assign sum  = src1 + src2;
   assign diff = src1 - src2;
   // Only the load/store bit of the instruction matters here.
   assign unused_instr = ^{instr[31:30], instr[28:0]};

   always_comb begin
      result    = 32'd0;
      alu_error = EXC_NONE;
      case (aluop)
         OP_ADDU: result = sum;
         OP_SUBU: result = diff;
         OP_ADD:  begin result = sum;  if (add_ovf(src1, src2, sum))  alu_error = EXC_OV;   end
         OP_SUB:  begin result = diff; if (sub_ovf(src1, src2, diff)) alu_error = EXC_OV;   end
         OP_AND:  result = src1 & src2;
         OP_OR:   result = src1 | src2;
         OP_XOR:  result = src1 ^ src2;
         OP_NOR:  result = ~(src1 | src2);
         OP_SLT:  result = {31'd0, $signed(src1) < $signed(src2)};
         OP_SLTU: result = {31'd0, src1 < src2};
         OP_SLL:  result = src2 << src1[4:0];
         OP_SRL:  result = src2 >> src1[4:0];
         OP_SRA:  result = $unsigned($signed(src2) >>> src1[4:0]);
         OP_LUI:  result = {src2[15:0], 16'd0};
         // Address adds report overflow as an address error of the access kind.
         OP_ADDL: begin result = sum; if (add_ovf(src1, src2, sum)) alu_error = EXC_ADEL; end
         OP_ADDS: begin result = sum; if (add_ovf(src1, src2, sum)) alu_error = EXC_ADES; end
         default: begin result = 32'd0; alu_error = EXC_NONE; end
      endcase
   end

   byte_enable_gen #(.DM_TOP(DM_TOP)) u_be (
      .addr     (result),
      .hbw      (hbw),
      .is_store (instr[29]),
      .be_out   (be_out),
      .be_error (be_error)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) bdout <= 1'b0;
      else        bdout <= bd;
   end

   // In a delay slot the exception must restart at the branch, one word back.
   assign pc_wout = bdout ? (pc_w - 32'd4) : pc_w;

endmodule

// File: tb/tb_alu_bd_be.sv
module tb_alu_bd_be;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] src1, src2, instr, pc_w;
   logic [4:0]  aluop;
   logic [1:0]  hbw;
   logic        bd;
   logic [31:0] result, pc_wout;
   logic [3:0]  alu_error, be_out, be_error;
   logic        bdout;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_bd_be dut (
      .clk(clk), .reset(reset), .src1(src1), .src2(src2), .aluop(aluop),
      .result(result), .alu_error(alu_error), .instr(instr), .hbw(hbw),
      .be_out(be_out), .be_error(be_error), .pc_w(pc_w), .bd(bd),
      .bdout(bdout), .pc_wout(pc_wout)
   );

   // Reference ALU: 64-bit signed arithmetic, overflow = result out of int32 range.
   function automatic void alu_model(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output logic [3:0] e);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint s;
      bit     ovf;
      r = 32'd0; e = 4'd0;
      s = 0; ovf = 0;
      case (op)
         5'd0: r = a + b;
         5'd1: r = a - b;
         5'd2, 5'd14, 5'd15: s = sa + sb;
         5'd3: s = sa - sb;
         5'd4: r = a & b;
         5'd5: r = a | b;
         5'd6: r = a ^ b;
         5'd7: r = ~(a | b);
         5'd8: r = (sa < sb) ? 32'd1 : 32'd0;
         5'd9: r = (a < b) ? 32'd1 : 32'd0;
         5'd10: r = b << a[4:0];
         5'd11: r = b >> a[4:0];
         5'd12: begin s = sb >>> a[4:0]; r = s[31:0]; end
         5'd13: r = b * 32'd65536;
         default: r = 32'd0;
      endcase
      if (op == 5'd2 || op == 5'd3 || op == 5'd14 || op == 5'd15) begin
         r   = s[31:0];
         ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         if (ovf) e = (op == 5'd14) ? 4'd4 : (op == 5'd15) ? 4'd5 : 4'd12;
      end
   endfunction

   // Reference byte enables: size in bytes, alignment by modulo, map by ranges.
   function automatic void be_model(input logic [31:0] addr, input logic [1:0] sz,
                                    input logic st, output logic [3:0] be,
                                    output logic [3:0] err);
      int size;
      int mask;
      bit bad = 0;
      be = 4'd0; err = 4'd0;
      if (sz == 2'b11) return;
      size = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
      if ((addr % size) != 0) bad = 1;
`ifdef ADDR_RANGE_CHECK_EN
      begin
         bit in_dm = (addr <= 32'h2FFF);
         bit in_io = (addr >= 32'h7F00 && addr <= 32'h7F0B) ||
                     (addr >= 32'h7F10 && addr <= 32'h7F1B);
         if (!in_dm && !in_io) bad = 1;
         if (in_io && size != 4) bad = 1;
         if (st && (addr == 32'h7F08 || addr == 32'h7F18)) bad = 1;
      end
`endif
      mask = ((1 << size) - 1) << (addr % 4);
      if (bad) err = st ? 4'd5 : 4'd4;
      else     be  = mask[3:0];
   endfunction

   task automatic test_reset;
      logic [31:0] er; logic [3:0] ee;
      reset = 1'b0; bd = 1'b1; pc_w = 32'h100; instr = 32'd0; hbw = 2'b11;
      src1 = 32'd5; src2 = 32'd7; aluop = 5'd0;
      #2;
      vectors++;
      if (bdout !== 1'b0) begin miscompares++; $display("FAIL reset_bdout got %b want 0", bdout); end
      alu_model(aluop, src1, src2, er, ee);
      vectors++;
      if (result !== er) begin miscompares++; $display("FAIL reset_alu got %h want %h", result, er); end
      vectors++;
      if (pc_wout !== 32'h100) begin miscompares++; $display("FAIL reset_pcw got %h want 00000100", pc_wout); end
      @(posedge clk); #1;
      vectors++;
      if (bdout !== 1'b0) begin miscompares++; $display("FAIL reset_hold got %b want 0", bdout); end
      @(negedge clk); reset = 1'b1; bd = 1'b0;
   endtask

   task automatic check_alu(input string name, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er; logic [3:0] ee;
      aluop = op; src1 = a; src2 = b; hbw = 2'b11;
      #1;
      alu_model(op, a, b, er, ee);
      vectors++;
      if (result !== er || alu_error !== ee) begin
         miscompares++;
         $display("FAIL %s op=%0d a=%h b=%h got %h/%0d want %h/%0d", name, op, a, b, result, alu_error, er, ee);
      end
   endtask

   task automatic test_alu_directed;
      aluop = 5'd2; src1 = 32'h7FFFFFFF; src2 = 32'd1; #1;
      vectors++;
      if (result !== 32'h80000000 || alu_error !== 4'd12) begin
         miscompares++; $display("FAIL add_ovf got %h/%0d want 80000000/12", result, alu_error);
      end
      aluop = 5'd0; #1;
      vectors++;
      if (alu_error !== 4'd0) begin miscompares++; $display("FAIL addu_noov got %0d want 0", alu_error); end
      aluop = 5'd12; src1 = 32'd4; src2 = 32'h80000000; #1;
      vectors++;
      if (result !== 32'hF8000000) begin miscompares++; $display("FAIL sra got %h want f8000000", result); end
      aluop = 5'd9; src1 = 32'd1; src2 = 32'hFFFFFFFF; #1;
      vectors++;
      if (result !== 32'd1) begin miscompares++; $display("FAIL sltu got %h want 1", result); end
      check_alu("sub_ovf",  5'd3,  32'h80000000, 32'd1);
      check_alu("addl_ovf", 5'd14, 32'h80000000, 32'hFFFFFFFF);
      check_alu("adds_ovf", 5'd15, 32'h7FFFFFF0, 32'h00000100);
      check_alu("slt_neg",  5'd8,  32'hFFFFFFFF, 32'd0);
      check_alu("lui",      5'd13, 32'd0,        32'h0000ABCD);
      check_alu("bad_op",   5'd31, 32'h7FFFFFFF, 32'd1);
   endtask

   task automatic test_alu_random;
      logic [31:0] a, b;
      for (int i = 0; i < 400; i++) begin
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 3) == 0) a = {a[31], {31{a[31] ^ 1'b1}}};
         if ($urandom_range(0, 3) == 0) b = {b[31], {31{b[31] ^ 1'b1}}};
         check_alu("alu_rand", 5'($urandom_range(0, 31)), a, b);
      end
   endtask

   task automatic check_be(input string name, input logic [31:0] addr,
                           input logic [1:0] sz, input logic st);
      logic [3:0] eb, ee;
      aluop = 5'd0; src1 = addr; src2 = 32'd0; hbw = sz;
      instr = $urandom; instr[29] = st;
      #1;
      be_model(addr, sz, st, eb, ee);
      vectors++;
      if (be_out !== eb || be_error !== ee) begin
         miscompares++;
         $display("FAIL %s addr=%h hbw=%b st=%b got be=%b err=%0d want be=%b err=%0d",
                  name, addr, sz, st, be_out, be_error, eb, ee);
      end
   endtask

   task automatic test_be_directed;
      aluop = 5'd0; src1 = 32'h2; src2 = 32'd0; hbw = 2'b01; instr = 32'h2000_0000; #1;
      vectors++;
      if (be_out !== 4'b1100 || be_error !== 4'd0) begin
         miscompares++; $display("FAIL half_store got %b/%0d want 1100/0", be_out, be_error);
      end
      src1 = 32'h1; hbw = 2'b00; instr = 32'h0; #1;
      vectors++;
      if (be_out !== 4'b0000 || be_error !== 4'd4) begin
         miscompares++; $display("FAIL word_misalign got %b/%0d want 0000/4", be_out, be_error);
      end
      src1 = 32'h7F00; hbw = 2'b10; instr = 32'h2000_0000; #1;
      vectors++;
`ifdef ADDR_RANGE_CHECK_EN
      if (be_error !== 4'd5 || be_out !== 4'b0000) begin
         miscompares++; $display("FAIL io_byte got %b/%0d want 0000/5", be_out, be_error);
      end
`else
      if (be_out !== 4'b0001 || be_error !== 4'd0) begin
         miscompares++; $display("FAIL io_byte got %b/%0d want 0001/0", be_out, be_error);
      end
`endif
      check_be("none",      32'h0000_0003, 2'b11, 1'b1);
      check_be("dm_top",    32'h0000_2FFC, 2'b00, 1'b0);
      check_be("past_top",  32'h0000_3000, 2'b00, 1'b0);
      check_be("io_ro_st",  32'h0000_7F18, 2'b00, 1'b1);
      check_be("io_ro_ld",  32'h0000_7F08, 2'b00, 1'b0);
   endtask

   task automatic test_be_random;
      logic [31:0] addr;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: addr = $urandom_range(0, 32'h3100);
            1: addr = 32'h7EF8 + $urandom_range(0, 32'h30);
            2: addr = $urandom;
            default: addr = 32'h2FF0 + $urandom_range(0, 32'h20);
         endcase
         check_be("be_rand", addr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_bd;
      logic prev_bd;
      logic [31:0] exp_pc;
      @(negedge clk); bd = 1'b1; pc_w = 32'h3000;
      @(negedge clk); bd = 1'b0; pc_w = 32'h3010; #1;
      vectors++;
      if (bdout !== 1'b1 || pc_wout !== 32'h300C) begin
         miscompares++; $display("FAIL bd_slot got %b/%h want 1/0000300c", bdout, pc_wout);
      end
      @(negedge clk); #1;
      vectors++;
      if (bdout !== 1'b0 || pc_wout !== 32'h3010) begin
         miscompares++; $display("FAIL bd_clear got %b/%h want 0/00003010", bdout, pc_wout);
      end
      prev_bd = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         bd = 1'($urandom_range(0, 1)); pc_w = $urandom; #1;
         exp_pc = prev_bd ? pc_w - 32'd4 : pc_w;
         vectors++;
         if (bdout !== prev_bd || pc_wout !== exp_pc) begin
            miscompares++; $display("FAIL bd_rand got %b/%h want %b/%h", bdout, pc_wout, prev_bd, exp_pc);
         end
         prev_bd = bd;
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk); bd = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (bdout !== 1'b1) begin miscompares++; $display("FAIL pre_reset got %b want 1", bdout); end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (bdout !== 1'b0) begin miscompares++; $display("FAIL async_reset got %b want 0", bdout); end
      @(negedge clk); reset = 1'b1; bd = 1'b0;
   endtask

   initial begin
      test_reset;
      test_alu_directed;
      test_alu_random;
      test_be_directed;
      test_be_random;
      test_bd;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_bd_be.md
ALU_BD_BE -- requirements
Module: alu_bd_be

Interface
REQ-001 Parameter DM_TOP, default 32'h0000_2FFF, SHALL set the last valid data-memory byte address.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 src1, src2  input  32 each  SHALL be the ALU operands.
REQ-005 aluop  input  5  SHALL select the ALU operation.
REQ-006 result  output  32  SHALL carry the ALU result.
REQ-007 alu_error  output  4  SHALL carry the ALU exception code.
REQ-008 instr  input  32  SHALL be the M-stage instruction; instr[29]=1 means store, 0 means load.
REQ-009 hbw  input  2  SHALL give the access size: 00 word, 01 half, 10 byte, 11 no access.
REQ-010 be_out  output  4  SHALL carry the byte enables.
REQ-011 be_error  output  4  SHALL carry the memory-access exception code.
REQ-012 pc_w  input  32  SHALL be the W-stage PC.
REQ-013 bd  input  1  SHALL be high when the W-stage instruction is a branch or jump.
REQ-014 bdout  output  1  SHALL flag that the current W-stage instruction sits in a delay slot.
REQ-015 pc_wout  output  32  SHALL carry the EPC candidate.

Function
REQ-016 The ALU and byte-enable paths SHALL be purely combinational with zero latency.
REQ-017 aluop encoding SHALL be:
- 0 ADDU, 1 SUBU, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOR
- 8 SLT (signed), 9 SLTU
- 10 SLL, 11 SRL, 12 SRA: each shifts src2 by src1[4:0]
- 13 LUI: src2<<16
- 14 ADDL (load address), 15 ADDS (store address)
- any other code SHALL give result 0 and alu_error 0.
REQ-018 Arithmetic SHALL be 32-bit wrap-around; SLT/SLTU SHALL return 32'd0 or 32'd1.
REQ-019 ADD/SUB signed overflow SHALL set alu_error=12 (Ov); the wrapped result SHALL still be driven.
REQ-020 ADDL/ADDS signed overflow SHALL set alu_error=4 (AdEL) or 5 (AdES) respectively.
REQ-021 With no error condition, alu_error SHALL be 0.
REQ-022 Byte enables from addr=result[1:0]:
- word: 4'b1111
- half: 4'b0011 << addr[1]*2
- byte: 4'b0001 << addr[1:0]
- hbw=11: 4'b0000 and be_error=0.
REQ-023 A word access with addr[1:0]!=0, or a half access with addr[0]=1, SHALL be misaligned.
REQ-024 Any be_error condition SHALL yield code 4 for a load or 5 for a store, and SHALL force be_out=0.
REQ-025 bdout SHALL be a register loading bd each cycle.
REQ-026 pc_wout SHALL equal pc_w-4 when bdout=1, else pc_w (combinational).

Reset
REQ-027 While reset=0, bdout SHALL be 0 immediately, independent of clk; the combinational outputs SHALL remain functional.

Configuration
REQ-028 With ADDR_RANGE_CHECK_EN defined, be_error SHALL also flag:
- addresses outside [0, DM_TOP], 0x7F00-0x7F0B and 0x7F10-0x7F1B;
- any non-word access to the 0x7Fxx ranges;
- stores to offsets 0x7F08 or 0x7F18.
REQ-029 Without ADDR_RANGE_CHECK_EN, be_error SHALL reflect alignment only.

Structure
REQ-030 A shared package alu_bd_be_pkg SHALL hold the aluop codes, the ExcCode constants (0, 4, 5, 12) and the address-map constants.
REQ-031 The byte-enable logic SHALL be one sub-module, byte_enable_gen; the ALU and BD SHALL stay inline.

Verification
REQ-032 ADD with src1=32'h7FFFFFFF, src2=1 -> result 32'h80000000, alu_error=12; the same inputs with ADDU -> alu_error=0.
REQ-033 SRA with src1=4, src2=32'h80000000 -> result 32'hF8000000; SLTU with src1=1, src2=32'hFFFFFFFF -> result 1.
REQ-034 Half store with result=32'h0000_0002 -> be_out=4'b1100, be_error=0; word load with result=32'h0000_0001 -> be_out=0, be_error=4.
REQ-035 Byte store to 32'h7F00 with ADDR_RANGE_CHECK_EN defined -> be_error=5; without the macro -> be_out=4'b0001.
REQ-036 Assert bd=1 for one cycle, then present pc_w=32'h3010 -> next cycle bdout=1 and pc_wout=32'h300C, the cycle after bdout=0.
REQ-037 Drop reset low mid-cycle while bdout=1 -> bdout=0 immediately.
